// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline control plane: FSM state encoding,
// debug-unit mode codes and a priority helper for stall requests.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_DRAIN = 2'b11;

  // Upper bound on pipeline depth supported by highest_set().
  localparam int MAX_STAGES = 32;

  function automatic int highest_set(input logic [MAX_STAGES-1:0] vec);
    int idx;
    idx = -1;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear has priority
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control plane: run/step/drain/halt sequencing for the debug unit,
// per-register write enables, bubble insertion and per-register valid tracking.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_STAGES = 4,
  parameter int NB_CNT    = 32,
  parameter int NB_STEP   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [1:0]           i_mode,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic [NB_STEP-1:0]   i_step_count,
  input  logic                 i_fetch_valid,
  input  logic [NB_STAGES-1:0] i_stall_req,
  input  logic [NB_STAGES-1:0] i_flush_req,
  input  logic                 i_halt_seen,
  output logic                 o_clk_en,
  output logic [NB_STAGES-1:0] o_stage_en,
  output logic [NB_STAGES-1:0] o_stage_bubble,
  output logic [NB_STAGES-1:0] o_valid,
  output logic [2:0]           o_state,
  output logic [NB_CNT-1:0]    o_cycle_cnt,
  output logic [NB_CNT-1:0]    o_retired_cnt,
  output logic                 o_done
);

  state_e               state_q, state_d;
  logic [NB_STEP-1:0]   step_q, step_d;
  logic                 done_q, done_d;
  logic [NB_STAGES-1:0] valid_q, valid_d;

  logic                 clk_en;
  logic                 start_ok;
  logic                 cnt_clr;
  logic                 retire_en;
  int                   stall_k;
  logic [NB_STAGES-1:0] stage_en;
  logic [NB_STAGES-1:0] bubble;
  logic                 fetch_in;
  logic [NB_STAGES-1:0] shift_in;

  // The datapath advances only from the registered state, never from inputs.
  assign clk_en    = state_q inside {ST_RUN, ST_STEP, ST_DRAIN};
  assign start_ok  = i_start && (i_mode != MODE_NONE) && (state_q == ST_IDLE);
  assign cnt_clr   = i_clear && ((state_q == ST_HALTED) ||
                                 ((state_q == ST_IDLE) && !start_ok));
  assign retire_en = clk_en && valid_q[NB_STAGES-1];

  // Stall at k holds 0..k and feeds a bubble into k+1; flushes add bubbles.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    stall_k  = highest_set(MAX_STAGES'(i_stall_req));
    stage_en = '0;
    bubble   = '0;
    for (int j = 0; j < NB_STAGES; j++) begin
      stage_en[j] = clk_en && (j > stall_k);
      bubble[j]   = clk_en && (((stall_k >= 0) && (j == stall_k + 1)) || i_flush_req[j]);
    end
  end

  always_comb begin
    fetch_in = i_fetch_valid && (state_q != ST_DRAIN);
    shift_in = {valid_q[NB_STAGES-2:0], fetch_in};
    valid_d  = valid_q;
    if (cnt_clr) begin
      valid_d = '0;
    end else begin
      for (int j = 0; j < NB_STAGES; j++) begin
        if (bubble[j])        valid_d[j] = 1'b0;
        else if (stage_en[j]) valid_d[j] = shift_in[j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          unique case (i_mode)
            MODE_RUN:   state_d = ST_RUN;
            MODE_STEP: begin
              state_d = ST_STEP;
              step_d  = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;
            end
            MODE_DRAIN: state_d = ST_DRAIN;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt_seen) state_d = ST_HALTED;
      end
      ST_STEP: begin
        if (i_halt_seen) begin
          state_d = ST_HALTED;
        end else if (step_q == NB_STEP'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          step_d = step_q - NB_STEP'(1);
        end
      end
      ST_DRAIN: begin
        // Finish on the cycle whose update empties the pipe, not one later.
        if (i_halt_seen) begin
          state_d = ST_HALTED;
        end else if (valid_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (i_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: asynchronous reset is in the sensitivity list so it acts between edges.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values.
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.WIDTH(NB_CNT)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (clk_en),
    .i_clr   (cnt_clr),
    .o_cnt   (o_cycle_cnt)
  );

  sat_counter #(.WIDTH(NB_CNT)) u_retired_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (retire_en),
    .i_clr   (cnt_clr),
    .o_cnt   (o_retired_cnt)
  );

  assign o_clk_en       = clk_en;
  assign o_stage_en     = stage_en;
  assign o_stage_bubble = bubble;
  assign o_valid        = valid_q;
  assign o_state        = state_q;
  assign o_done         = done_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control plane for the MIPS core: owns per-stage valid bits, per-stage write enables and bubble insertion, and the run/step/drain/halt sequencing that gates the datapath through the debug unit. It replaces the single global `i_dunit_clk_en` plus ad-hoc stall/flush wiring with a per-register enable vector for any number of pipeline registers. It sits between the debug unit and the pipeline top; hazard and forwarding units feed it requests.

## Interface
Parameters:
- `NB_STAGES`, 4: number of pipeline registers; index 0 = IF/ID, index `NB_STAGES-1` = M/WB.
- `NB_CNT`, 32: width of the cycle and retired counters.
- `NB_STEP`, 8: width of the step-count input.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk` in 1: clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_mode` in 2: 00 none, 01 run, 10 step, 11 drain.
- `i_start` in 1: pulse; accepted only in IDLE.
- `i_clear` in 1: pulse; leaves HALTED.
- `i_step_count` in `NB_STEP`: number of cycles for step mode; 0 is treated as 1.
- `i_fetch_valid` in 1: IF produced an instruction this cycle.
- `i_stall_req` in `NB_STAGES`: bit k set means hold registers 0..k.
- `i_flush_req` in `NB_STAGES`: bit j set means register j loads a bubble.
- `i_halt_seen` in 1: halt instruction is in M/WB.
- `o_clk_en` out 1: global advance enable.
- `o_stage_en` out `NB_STAGES`: per-register write enable.
- `o_stage_bubble` out `NB_STAGES`: per-register zero-control load.
- `o_valid` out `NB_STAGES`: valid bit of each register.
- `o_state` out 3: current FSM state.
- `o_cycle_cnt` out `NB_CNT`: number of enabled cycles.
- `o_retired_cnt` out `NB_CNT`: number of instructions retired from M/WB.
- `o_done` out 1: one-cycle pulse when step or drain completes.

## Operation
States: IDLE, RUN, STEP, DRAIN, HALTED.

Transitions:
- IDLE + `i_start`: mode 01 goes to RUN, 10 goes to STEP (loads the step counter), 11 goes to DRAIN. Mode 00 is ignored.
- RUN stays in RUN until `i_halt_seen` is high in an enabled cycle, then goes to HALTED.
- STEP decrements its counter every cycle. The cycle in which the counter equals 1 is the last; the FSM then goes to IDLE and pulses `o_done`. `i_halt_seen` takes priority and goes to HALTED with no `o_done`.
- DRAIN forces the input of register 0 to invalid. When `o_valid` is all zero, the FSM goes to IDLE and pulses `o_done`. `i_halt_seen` goes to HALTED.
- HALTED + `i_clear` goes to IDLE, clears `o_valid` and both counters. `i_start` is ignored in HALTED.

Enables and valid bits:
- `o_clk_en` = state is RUN, STEP or DRAIN. It is a decode of the registered state only.
- Let k = highest set bit of `i_stall_req`. `o_stage_en[j]` = `o_clk_en` and j > k (with no stall, every bit equals `o_clk_en`).
- `o_stage_bubble[k+1]` = 1 when k+1 < `NB_STAGES`. `o_stage_bubble[j]` = 1 also when `i_flush_req[j]` is set.
- Enabled, non-bubbled register j loads `o_valid[j-1]`. Register 0 loads `i_fetch_valid` (forced 0 in DRAIN).
- A bubble clears `o_valid[j]`. Flush wins over hold.
- Bubble outputs are gated by `o_clk_en`.

Counters:
- `o_cycle_cnt` increments when `o_clk_en` is high.
- `o_retired_cnt` increments when `o_clk_en` and `o_valid[NB_STAGES-1]` are both high.
- Both saturate at all-ones; they never wrap.

## Timing
- Reset values: state IDLE. `o_clk_en`, `o_stage_en`, `o_stage_bubble`, `o_valid`, both counters and `o_done` are all 0.
- Reset mid-operation aborts immediately; in-flight valid bits are lost.
- `i_start` at edge t gives `o_clk_en` high from cycle t+1.
- Step of N gives exactly N cycles of `o_clk_en`. `o_done` is high in the cycle after the last enabled cycle, and `o_clk_en` is already 0 in that cycle.
- `o_stage_en` and `o_stage_bubble` are combinational from `i_stall_req`, `i_flush_req` and the state, with zero latency.
- `o_valid` updates at the next edge.
- Halt: the enabled cycle that samples `i_halt_seen` still counts and retires. `o_clk_en` is 0 from the next cycle.
- Drain with the pipe already empty completes in 1 enabled cycle.
- Simultaneous `i_start` and `i_clear` in IDLE: `i_start` wins.

## Structure
- `pipe_ctrl_pkg` holds the state enum (3-bit encoding), the mode constants (`MODE_NONE`, `MODE_RUN`, `MODE_STEP`, `MODE_DRAIN`) and a function `highest_set(vec)` returning index or -1.
- One sub-module, `sat_counter`, parametrised width, with enable and synchronous clear. It is instantiated twice.

## Test plan
- Reset, then `i_mode`=01 with `i_start` and `i_fetch_valid`=1, `NB_STAGES`=4: `o_valid` goes 0001, 0011, 0111, 1111 over 4 cycles. `o_retired_cnt` = 1 after cycle 5.
- Step with `i_step_count`=3: exactly 3 `o_clk_en` cycles, `o_cycle_cnt`=3, `o_done` pulse, state IDLE. Step with count 0 gives exactly 1 cycle.
- RUN, pipe full, `i_stall_req`=0010 for one cycle: `o_stage_en`=1100, `o_stage_bubble`=0100. Next cycle `o_valid[2]`=0 and `o_valid[1:0]` are unchanged.
- `i_stall_req`=0001 together with `i_flush_req`=0001: `o_valid[0]` cleared (flush wins), `o_stage_en[0]`=0.
- Full pipe, drain: `o_done` after 4 enabled cycles, `o_valid`=0000, `o_retired_cnt`=4. `i_halt_seen` in RUN gives HALTED and `o_clk_en`=0. `i_start` is then ignored; `i_clear` returns to IDLE with counters at 0.
- Assert `i_reset` mid-RUN between clock edges: all outputs 0 immediately. `o_cycle_cnt` forced to all-ones saturates and does not wrap.
